// File: rtl/spi_slave_mem_pkg.sv
// Shared types and constants for the SPI-to-memory responder.
package spi_slave_mem_pkg;

    localparam int unsigned DATA_W = 32;

    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] CMD_STATUS = 8'h05;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        DUMMY,
        RDATA,
        SKIP
    } state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_slave_sync.sv
// Two-flop synchronisers for the SPI pins plus edge detection on SCLK and CS.
module spi_slave_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk,
    input  logic cs,
    input  logic sdi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_rise,
    output logic cs_fall,
    output logic cs_sync,
    output logic sdi_sync
);

    // Stages [1:0] synchronise, stage [2] holds the previous level for edge detection.
    logic [2:0] sclk_q;
    logic [2:0] cs_q;
    logic [1:0] sdi_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sclk_q <= '0;
            cs_q   <= '1;
            sdi_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], sclk};
            cs_q   <= {cs_q[1:0], cs};
            sdi_q  <= {sdi_q[0], sdi};
        end
    end

    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign cs_sync   = cs_q[1];
    assign sdi_sync  = sdi_q[1];

endmodule

// File: rtl/spi_slave_mem.sv
// SPI mode-0 responder translating command/address/data frames into memory requests.
// Optional status command 0x05 is enabled by defining SPI_SLAVE_MEM_STATUS_EN.
module spi_slave_mem
    import spi_slave_mem_pkg::*;
#(
    parameter int unsigned DUMMY_CYCLES = 34,
    parameter int unsigned ADDR_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              spi_sclk,
    input  logic              spi_cs,
    input  logic              spi_sdi,
    output logic              spi_sdo,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = $clog2(max_u(max_u(ADDR_W, DUMMY_CYCLES), DATA_W));

    logic sclk_rise, sclk_fall, cs_rise, cs_fall, cs_sync, sdi_sync;

    spi_slave_sync u_sync (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .sclk      (spi_sclk),
        .cs        (spi_cs),
        .sdi       (spi_sdi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_rise   (cs_rise),
        .cs_fall   (cs_fall),
        .cs_sync   (cs_sync),
        .sdi_sync  (sdi_sync)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-2:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              sdo_q, sdo_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic              err_q, err_d;
    logic              rd_pend_q, rd_pend_d;
    logic              rd_have_q, rd_have_d;

    logic [7:0]        cmd_next;
    logic [ADDR_W-1:0] next_addr;
    logic [DATA_W-1:0] next_wdata;
    logic [ADDR_W-1:0] issue_addr;
    logic              issue, issue_we, start_rd;

    assign cmd_next   = {cmd_q[6:0], sdi_sync};
    assign next_addr  = {addr_q[ADDR_W-2:0], sdi_sync};
    assign next_wdata = {wdata_q, sdi_sync};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tx_d       = tx_q;
        sdo_d      = sdo_q;
        req_d      = req_q;
        we_d       = we_q;
        maddr_d    = maddr_q;
        mwdata_d   = mwdata_q;
        err_d      = err_q;
        rd_pend_d  = rd_pend_q;
        rd_have_d  = rd_have_q;
        issue      = 1'b0;
        issue_we   = 1'b0;
        issue_addr = addr_q;
        start_rd   = 1'b0;

        if (req_q && mem_gnt) begin
            req_d = 1'b0;
        end
        if (rd_pend_q && mem_rvalid) begin
            tx_d      = mem_rdata;
            rd_have_d = 1'b1;
            rd_pend_d = 1'b0;
        end

        // CS release takes priority over any SCLK edge seen in the same cycle.
        if (cs_rise) begin
            state_d = IDLE;
            sdo_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_d = CMD;
                        cnt_d   = CNT_W'(7);
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d = cmd_next;
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            if (cmd_next == CMD_WRITE || cmd_next == CMD_READ) begin
                                state_d = ADDR;
                                cnt_d   = CNT_W'(ADDR_W - 1);
                            end
`ifdef SPI_SLAVE_MEM_STATUS_EN
                            else if (cmd_next == CMD_STATUS) begin
                                state_d = RDATA;
                                cnt_d   = CNT_W'(7);
                                tx_d    = {err_q, req_q, 30'd0};
                            end
`endif
                            else begin
                                state_d = SKIP;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        addr_d = next_addr;
                        cnt_d  = cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            if (cmd_q == CMD_WRITE) begin
                                state_d = WDATA;
                                cnt_d   = CNT_W'(DATA_W - 1);
                            end else begin
                                issue      = 1'b1;
                                issue_addr = next_addr;
                                rd_have_d  = 1'b0;
                                if (DUMMY_CYCLES == 0) begin
                                    start_rd = 1'b1;
                                end else begin
                                    state_d = DUMMY;
                                    cnt_d   = CNT_W'(DUMMY_CYCLES - 1);
                                end
                            end
                        end
                    end
                end
                WDATA: begin
                    if (sclk_rise) begin
                        wdata_d = next_wdata[DATA_W-2:0];
                        cnt_d   = cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            issue    = 1'b1;
                            issue_we = 1'b1;
                            state_d  = CMD;
                            cnt_d    = CNT_W'(7);
                        end
                    end
                end
                DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            start_rd = 1'b1;
                        end
                    end
                end
                RDATA: begin
                    if (sclk_fall) begin
                        sdo_d = tx_q[DATA_W-1];
                        tx_d  = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == '0) begin
                            state_d = CMD;
                            cnt_d   = CNT_W'(7);
                            sdo_d   = 1'b0;
                        end
                    end
                end
                SKIP: ;
                default: state_d = IDLE;
            endcase
        end

        if (issue) begin
            if (req_q) begin
                err_d = 1'b1;
            end else begin
                req_d   = 1'b1;
                we_d    = issue_we;
                maddr_d = issue_addr;
                if (issue_we) begin
                    mwdata_d = next_wdata;
                end else begin
                    rd_pend_d = 1'b1;
                end
            end
        end

        // Read data not back by the end of the dummy phase: send zeros, flag, drop late data.
        if (start_rd) begin
            state_d   = RDATA;
            cnt_d     = CNT_W'(DATA_W - 1);
            rd_pend_d = 1'b0;
            rd_have_d = 1'b0;
            if (!(rd_have_q || (rd_pend_q && mem_rvalid))) begin
                tx_d  = '0;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
            sdo_q     <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            maddr_q   <= '0;
            mwdata_q  <= '0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            rd_have_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            sdo_q     <= sdo_d;
            req_q     <= req_d;
            we_q      <= we_d;
            maddr_q   <= maddr_d;
            mwdata_q  <= mwdata_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
            rd_have_q <= rd_have_d;
        end
    end

    assign spi_sdo   = sdo_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign err_o     = err_q;
    assign busy_o    = ~cs_sync | req_q;

endmodule

// File: tb/tb_spi_slave_mem.sv
// Directed bench for spi_slave_mem: SPI master tasks plus a grant/rvalid memory responder.
module tb_spi_slave_mem;

    localparam int HALF = 80;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        spi_sclk, spi_cs, spi_sdi, spi_sdo;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid, busy_o, err_o;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int tests_run    = 0;
    int tests_failed = 0;

    int          gnt_stall = 0;
    int          rv_delay  = 4;
    bit          rv_en     = 1'b1;
    int          req_cnt   = 0;
    bit          held_ok   = 1'b1;
    bit          drop_ok   = 1'b1;
    logic        last_we;
    logic [31:0] last_addr, last_wdata;
    logic [31:0] mem_model [256];

    always #5 clk_i = ~clk_i;

    spi_slave_mem dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .spi_sclk   (spi_sclk),
        .spi_cs     (spi_cs),
        .spi_sdi    (spi_sdi),
        .spi_sdo    (spi_sdo),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory responder: grant after gnt_stall cycles, read data rv_delay cycles after grant.
    initial begin : responder
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        for (int i = 0; i < 256; i++) mem_model[i] = '0;
        forever begin
            @(negedge clk_i);
            if (mem_req === 1'b1 && rst_ni === 1'b1) begin
                req_cnt++;
                last_we    = mem_we;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
                for (int i = 0; i < gnt_stall; i++) begin
                    @(negedge clk_i);
                    if (mem_req !== 1'b1 || mem_addr !== last_addr || mem_wdata !== last_wdata)
                        held_ok = 1'b0;
                end
                mem_gnt = 1'b1;
                @(negedge clk_i);
                mem_gnt = 1'b0;
                if (mem_req !== 1'b0) drop_ok = 1'b0;
                if (last_we) begin
                    mem_model[last_addr[7:0]] = last_wdata;
                end else if (rv_en) begin
                    repeat (rv_delay - 1) @(negedge clk_i);
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_model[last_addr[7:0]];
                    @(negedge clk_i);
                    mem_rvalid = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic spi_shift(input logic [63:0] dout, input int n, output logic [63:0] din);
        din = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_sdi = dout[i];
            #HALF;
            din = {din[62:0], spi_sdo};
            spi_sclk = 1'b1;
            #HALF;
            spi_sclk = 1'b0;
        end
        spi_sdi = 1'b0;
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        #HALF;
    endtask

    task automatic cs_high();
        #HALF;
        spi_cs = 1'b1;
        #(HALF * 2);
    endtask

    task automatic write_frame(input logic [31:0] addr, input logic [31:0] data);
        logic [63:0] d;
        spi_shift(64'h02, 8, d);
        spi_shift({32'd0, addr}, 32, d);
        spi_shift({32'd0, data}, 32, d);
    endtask

    task automatic read_frame(input logic [31:0] addr, output logic [31:0] rdata,
                              output logic [63:0] dummy_seen);
        logic [63:0] d;
        spi_shift(64'h0B, 8, d);
        spi_shift({32'd0, addr}, 32, d);
        spi_shift(64'd0, 34, dummy_seen);
        spi_shift(64'd0, 32, d);
        rdata = d[31:0];
    endtask

    initial begin : stimulus
        int          base;
        logic [31:0] rd;
        logic [63:0] dm, din;

        rst_ni   = 1'b0;
        spi_sclk = 1'b0;
        spi_cs   = 1'b1;
        spi_sdi  = 1'b0;
        repeat (5) @(negedge clk_i);
        check("rst_sdo", spi_sdo, 0);
        check("rst_req", mem_req, 0);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_busy", busy_o, 0);
        check("rst_err", err_o, 0);
        rst_ni = 1'b1;
        repeat (5) @(negedge clk_i);

        // Write 0x02, addr 100, data 100, immediate grant.
        base = req_cnt;
        cs_low();
        check("wr0_busy", busy_o, 1);
        write_frame(32'd100, 32'd100);
        cs_high();
        repeat (20) @(negedge clk_i);
        check("wr0_count", req_cnt - base, 1);
        check("wr0_we", last_we, 1);
        check("wr0_addr", last_addr, 100);
        check("wr0_wdata", last_wdata, 100);
        check("wr0_drop", drop_ok, 1);
        check("wr0_busy_idle", busy_o, 0);

        // Same write, granted after 5 stall cycles.
        base      = req_cnt;
        gnt_stall = 5;
        cs_low();
        write_frame(32'd100, 32'd100);
        cs_high();
        repeat (20) @(negedge clk_i);
        gnt_stall = 0;
        check("wr5_count", req_cnt - base, 1);
        check("wr5_held", held_ok, 1);
        check("wr5_drop", drop_ok, 1);
        check("wr5_addr", last_addr, 100);
        check("wr5_err", err_o, 0);

        // Read 0x0B, addr 100, rvalid 4 cycles after grant.
        base = req_cnt;
        cs_low();
        read_frame(32'd100, rd, dm);
        cs_high();
        check("rd_count", req_cnt - base, 1);
        check("rd_we", last_we, 0);
        check("rd_addr", last_addr, 100);
        check("rd_dummy_sdo", dm, 0);
        check("rd_data", rd, 32'h0000_0064);
        check("rd_err", err_o, 0);

        // Write then read chained under one CS assertion.
        base = req_cnt;
        cs_low();
        write_frame(32'd7, 32'hCAFE_F00D);
        read_frame(32'd7, rd, dm);
        cs_high();
        check("chain_count", req_cnt - base, 2);
        check("chain_data", rd, 32'hCAFE_F00D);

        // Unknown command: no request, sdo low, next frame decodes normally.
        base = req_cnt;
        cs_low();
        spi_shift(64'h55, 8, din);
        check("skip_cmd_sdo", din, 0);
        spi_shift('1, 64, din);
        check("skip_sdo", din, 0);
        cs_high();
        check("skip_count", req_cnt - base, 0);
        cs_low();
        read_frame(32'd100, rd, dm);
        cs_high();
        check("skip_next_data", rd, 32'h0000_0064);

        // Abort after 20 address bits.
        repeat (10) @(negedge clk_i);
        base = req_cnt;
        cs_low();
        spi_shift(64'h02, 8, din);
        spi_shift(64'hABCDE, 20, din);
        spi_cs = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("abort_busy", busy_o, 0);
        @(negedge clk_i);
        repeat (50) @(negedge clk_i);
        check("abort_count", req_cnt - base, 0);
        check("abort_sdo", spi_sdo, 0);
        base = req_cnt;
        cs_low();
        write_frame(32'd9, 32'h1234_5678);
        cs_high();
        repeat (20) @(negedge clk_i);
        check("abort_next_count", req_cnt - base, 1);
        check("abort_next_addr", last_addr, 9);
        check("abort_next_wdata", last_wdata, 32'h1234_5678);

        // rvalid withheld: zeros shifted, sticky error.
        rv_en = 1'b0;
        cs_low();
        read_frame(32'd100, rd, dm);
        cs_high();
        rv_en = 1'b1;
        check("late_data", rd, 0);
        check("late_err", err_o, 1);
        cs_low();
        read_frame(32'd9, rd, dm);
        cs_high();
        check("late_next_data", rd, 32'h1234_5678);
        check("late_err_sticky", err_o, 1);

        // Reset while a request is pending clears it along with the error.
        gnt_stall = 300;
        cs_low();
        write_frame(32'd20, 32'h5555_AAAA);
        cs_high();
        check("pend_req", mem_req, 1);
        check("pend_busy", busy_o, 1);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_err", err_o, 0);
        check("mid_rst_busy", busy_o, 0);
        check("mid_rst_addr", mem_addr, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (400) @(negedge clk_i);
        gnt_stall = 0;
        check("post_rst_req", mem_req, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/spi_slave_mem.md
# spi_slave_mem

SPI responder that terminates the stimulus SPI link inside the test chip. It deserialises command/address/data frames sent by the FPGA-side `spi_master`, and drives a simple request/grant memory port. For read commands it serialises the returned word back onto `spi_sdo`. It sits between the chip SPI pads and the on-chip memory or bus bridge, and shares the master's frame format.

## Interface
Parameters:
- `DUMMY_CYCLES`, default 34: SCLK cycles between the last address bit and the first read-data bit.
- `ADDR_W`, default 32: address field width, transmitted MSB first.

Ports:
- `clk_i`  in  1  system clock; must be ≥ 8× SCLK frequency.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `spi_sclk`  in  1  SPI clock, idle low; asynchronous to `clk_i`.
- `spi_cs`  in  1  chip select, active-low; asynchronous.
- `spi_sdi`  in  1  serial data from master.
- `spi_sdo`  out  1  serial data to master.
- `mem_req`  out  1  memory request; held until `mem_gnt`.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  word address as received.
- `mem_wdata`  out  32  write data.
- `mem_gnt`  in  1  request accepted this cycle.
- `mem_rvalid`  in  1  read data valid, one cycle.
- `mem_rdata`  in  32  read data.
- `busy_o`  out  1  high while `spi_cs` is low (synchronised) or `mem_req` is pending.
- `err_o`  out  1  sticky error flag; cleared only by reset.

## Operation
- `spi_sclk`, `spi_cs` and `spi_sdi` each pass through a 2-FF synchroniser. Rising and falling SCLK edges are detected from the synchronised value.
- Data is sampled on SCLK rising edges and `spi_sdo` changes on falling edges (mode 0). All fields are MSB first.
- Frame: CMD (8 bits), then ADDR (ADDR_W bits), then the command-specific phase.
  - Command 0x02 (write): WDATA, 32 bits.
  - Command 0x0B (read): DUMMY (DUMMY_CYCLES bits), then RDATA (32 bits).
- After a complete frame the FSM returns to CMD while CS stays low, so frames may be chained without deasserting CS.
- FSM states and transitions:
  - IDLE → CMD on synchronised CS falling.
  - CMD → ADDR after the 8th bit.
  - ADDR → WDATA for 0x02, or DUMMY for 0x0B, after the ADDR_W-th bit. An unknown command goes to SKIP instead.
  - SKIP ignores all bits until CS rises.
- Write: after the 32nd WDATA bit, assert `mem_req=1`, `mem_we=1` with the captured address and data.
- Read: after the last ADDR bit, assert `mem_req=1`, `mem_we=0`. Capture `mem_rdata` on `mem_rvalid` into the TX shift register.
  - The first RDATA bit appears on `spi_sdo` at the falling edge ending the last DUMMY cycle.
  - If `mem_rvalid` has not arrived by then, shift zeros for the whole word and set `err_o`. A late `mem_rvalid` is discarded.
- `spi_sdo` is 0 outside RDATA.
- A new request while the previous `mem_req` is still ungranted is dropped and sets `err_o`.
- A bit counter reloads at each phase entry; its width must cover max(ADDR_W, DUMMY_CYCLES).

## Timing
- Reset values: `spi_sdo=0`, `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`, `busy_o=0`, `err_o=0`; FSM in IDLE.
- SCLK edge to internal detection: 3 `clk_i` cycles (2 sync stages plus the edge register).
- `mem_req` rises 1 cycle after the detected edge that completes the field. It stays high, with address and data stable, through the cycle `mem_gnt=1` and deasserts the next cycle.
- `spi_sdo` updates 1 cycle after the detected falling edge.
- CS rising mid-frame aborts to IDLE within 3 cycles with no `mem_req` for the partial frame. An already-issued `mem_req` stays held until granted.
- CS rising and an SCLK edge detected in the same cycle: CS wins and the bit is dropped.
- Reset mid-operation clears everything immediately, including a pending `mem_req`.

## Configuration
- `SPI_SLAVE_MEM_STATUS_EN`
  - Defined: command 0x05 is legal. It skips ADDR and enters RDATA immediately. It returns 8 status bits `{err_o, busy_mem, 6'b0}`, then returns to CMD.
  - Undefined: 0x05 is an unknown command and goes to SKIP.

## Structure
- `spi_slave_mem_pkg`: FSM state enum (IDLE, CMD, ADDR, WDATA, DUMMY, RDATA, SKIP), command constants `CMD_WRITE=8'h02`, `CMD_READ=8'h0B`, `CMD_STATUS=8'h05`, and data width 32.
- Sub-module `spi_slave_sync`: 2-FF synchroniser plus edge detector, instantiated for SCLK/CS/SDI. It outputs the synchronised levels and `sclk_rise`/`sclk_fall`/`cs_fall`/`cs_rise` pulses.

## Test plan
- Write 0x02, addr 100, data 100 → one `mem_req` with `mem_we=1`, `mem_addr=100`, `mem_wdata=100`; granted after 0 and after 5 stall cycles.
- Read 0x0B, addr 100, with `mem_rvalid` 4 cycles after grant and `mem_rdata=0x00000064` → `spi_sdo` returns 0x00000064 after exactly 34 dummy cycles; `err_o=0`.
- Write then read chained under one CS assertion (the FPGA stimulus sequence) → two requests, read returns the written value from a bench memory model.
- Command 0x55 → no `mem_req`, `spi_sdo=0` until CS rises, next frame decodes normally.
- CS deasserted after 20 address bits → no `mem_req`, IDLE, `busy_o=0` within 3 cycles.
- `mem_rvalid` withheld past the dummy phase → `spi_sdo` shifts 0x00000000, `err_o=1` stays set until `rst_ni` is asserted.
